pwm_meter: RTL and testbench
============================

PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 Parameter CNT_W, default 20: width of period/high-time counters and of period_cyc.
REQ-002 Parameter TIMEOUT, default 1_000_000: clk cycles without a rising edge before a stuck condition is declared; SHALL satisfy 2 <= TIMEOUT < 2^CNT_W.
REQ-003 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 pwm_in  in  1  PWM signal to be measured, asynchronous to clk.
REQ-006 duty_pct  out  7  last measured duty cycle, integer percent 0..100.
REQ-007 period_cyc  out  CNT_W  last measured period in clk cycles; 0 after a stuck report.
REQ-008 meas_valid  out  1  one-cycle pulse when duty_pct/period_cyc update.
REQ-009 busy  out  1  high while the divider runs.
REQ-010 stuck  out  1  high while the last report was a timeout.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; all logic uses the synced level s.
REQ-012 Rising edge R SHALL be detected as s=1 with the previous s=0; the detect cycle is the edge cycle.
REQ-013 States: IDLE (await first R), MEASURE.
REQ-014 IDLE: on R, period counter := 1, high counter := 1, go to MEASURE; no report.
REQ-015 MEASURE, no R: period counter +1 per cycle; high counter +1 when s=1.
REQ-016 MEASURE, R with divider idle: capture P = period counter and H = high counter, start the divider, restart both counters at 1.
REQ-017 MEASURE, R with divider busy: measurement dropped, counters restart at 1, divider unaffected.
REQ-018 Divider: restoring, 1 quotient bit per cycle, numerator H*100 (CNT_W+7 bits), denominator P; quotient floor(H*100/P), saturated to 100.
REQ-019 Latency: meas_valid SHALL assert exactly CNT_W+8 cycles after the edge cycle of a captured R; busy high from edge cycle+1 through the meas_valid cycle.
REQ-020 On meas_valid: duty_pct := quotient, period_cyc := P, stuck := 0, all in the same cycle as the pulse.
REQ-021 Timeout: period counter reaching TIMEOUT in MEASURE with divider idle SHALL produce a meas_valid pulse the next cycle with duty_pct = 100 if s=1 else 0, period_cyc = 0, stuck := 1; state -> IDLE.
REQ-022 Timeout while divider busy SHALL be deferred until the divider result has been reported, then reported as in REQ-021.
REQ-023 R and timeout in the same cycle: R wins; no timeout report.
REQ-024 Counters SHALL never wrap; TIMEOUT bounds them.
REQ-025 Outputs hold their values between meas_valid pulses.

Reset
REQ-026 rst=0 SHALL immediately force duty_pct=0, period_cyc=0, meas_valid=0, busy=0, stuck=0, synchronizer flops 0, counters 0, state IDLE, divider cleared.
REQ-027 Reset mid-divide SHALL discard the measurement; no meas_valid after release until a fresh full period is measured.
REQ-028 The first R after reset release only starts measurement (REQ-014).

Verification (CNT_W=20, TIMEOUT=1000)
REQ-029 Period 200 clk, high 50, repeated -> from 2nd R on: meas_valid 28 cycles after each edge cycle; duty_pct=25, period_cyc=200, stuck=0.
REQ-030 Period 200, high 199 -> duty_pct=99 (floor); high 200/period 200 unreachable: held-high input -> 1000 cycles after last R a pulse with duty_pct=100, period_cyc=0, stuck=1.
REQ-031 Pulses then pwm_in held low -> timeout pulse with duty_pct=0, stuck=1; next two rising edges, period 100, high 30 -> duty_pct=30, stuck=0.
REQ-032 Period 10, high 5 -> only edges arriving with busy=0 are captured; every meas_valid reports duty_pct=50, period_cyc=10; pulses spaced >= 28 cycles.
REQ-033 Assert rst 10 cycles after a captured R -> all outputs 0 at once; after release no meas_valid until 2 further R's.
REQ-034 First R after reset with 600 idle-low cycles before it -> no meas_valid from that R; timeout not reported from IDLE.

Source files
------------

// File: rtl/pwm_meter.sv
// pwm_meter: measures the period and duty cycle of an asynchronous PWM input,
// reporting floor(high*100/period) through a bit-serial restoring divider.
module pwm_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [6:0]       duty_pct,
  output logic [CNT_W-1:0] period_cyc,
  output logic             meas_valid,
  output logic             busy,
  output logic             stuck
);
  localparam int QW = CNT_W + 7;
  localparam int SW = $clog2(QW + 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state, state_nxt;
  logic s1, s, s_d, rise, cap, tmo, fin, ge;
  logic [CNT_W-1:0] per_cnt, high_cnt, den, rem, rem_nxt;
  logic [CNT_W:0] trial;
  logic [QW-1:0] num, quo, quo_nxt;
  logic [SW-1:0] step;

  assign rise = s & ~s_d;
  assign cap = (state == MEASURE) && rise && !busy;
  assign tmo = (state == MEASURE) && !rise && !busy && per_cnt == TO;
  assign fin = busy && step == SW'(1);
  assign trial = {rem, num[QW-1]};
  assign ge = trial >= {1'b0, den};
  assign rem_nxt = ge ? CNT_W'(trial - {1'b0, den}) : trial[CNT_W-1:0];
  assign quo_nxt = {quo[QW-2:0], ge};

  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && rise) ? MEASURE : tmo ? IDLE : state;
  end

  // counters saturate at TIMEOUT so a deferred timeout can never wrap them
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1, s, s_d} <= '0;
      state <= IDLE;
      per_cnt <= '0;
      high_cnt <= '0;
    end else begin
      s1 <= pwm_in;
      s <= s1;
      s_d <= s;
      state <= state_nxt;
      if (rise) begin
        per_cnt <= CNT_W'(1);
        high_cnt <= CNT_W'(1);
      end else if (state == MEASURE && per_cnt != TO) begin
        per_cnt <= per_cnt + CNT_W'(1);
        high_cnt <= high_cnt + CNT_W'(s);
      end
    end

  // busy stays up through the result cycle; meas_valid drops it afterwards
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      den <= '0;
      num <= '0;
      quo <= '0;
      rem <= '0;
      step <= '0;
      busy <= 1'b0;
      duty_pct <= '0;
      period_cyc <= '0;
      meas_valid <= 1'b0;
      stuck <= 1'b0;
    end else begin
      meas_valid <= fin | tmo;
      if (cap) begin
        den <= per_cnt;
        num <= QW'(high_cnt) * QW'(100);
        rem <= '0;
        quo <= '0;
        step <= SW'(QW);
        busy <= 1'b1;
      end else if (busy) begin
        if (step != '0) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          num <= num << 1;
          step <= step - SW'(1);
        end
        if (meas_valid) busy <= 1'b0;
      end
      if (fin) begin
        duty_pct <= quo_nxt > QW'(100) ? 7'd100 : quo_nxt[6:0];
        period_cyc <= den;
        stuck <= 1'b0;
      end else if (tmo) begin
        duty_pct <= s ? 7'd100 : 7'd0;
        period_cyc <= '0;
        stuck <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: randomized and directed PWM stimulus; expected reports come from
// edge timestamps and high-sample sums, queued and matched by a separate monitor.
module tb_pwm_meter;
  localparam int CNT_W = 20;
  localparam int T = 1000;
  localparam int LAT = CNT_W + 8;
  localparam int MAXC = 80000;
  logic clk = 1'b0, rst = 1'b1, pwm_in = 1'b0;
  logic [6:0] duty_pct;
  logic [CNT_W-1:0] period_cyc;
  logic meas_valid, busy, stuck;

  pwm_meter #(.CNT_W(CNT_W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty_pct(duty_pct),
    .period_cyc(period_cyc), .meas_valid(meas_valid), .busy(busy), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {int duty; int per; int stk; int cyc;} exp_t;
  exp_t sb[$];
  exp_t x;
  int cyc = 0, errors = 0, checks = 0;
  bit v[MAXC];
  bit in_meas = 0, has_cap = 0, exp_busy = 0;
  int e = 0, cap_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // synchronized level seen by the design in cycle k: input of two cycles earlier
  function automatic bit s_at(int k);
    return (k >= 2) ? v[k-2] : 1'b0;
  endfunction

  task automatic model(input int n);
    bit s, rise, bsy;
    int p, h, q;
    s = s_at(n);
    rise = s && !s_at(n - 1);
    bsy = has_cap && n > cap_c && n <= cap_c + LAT;
    exp_busy = bsy;
    if (rise) begin
      if (in_meas && !bsy) begin
        p = (n - e < T) ? n - e : T;
        h = 0;
        for (int k = e; k < e + p; k++) h += int'(s_at(k));
        q = h * 100 / p;
        sb.push_back('{(q > 100) ? 100 : q, p, 0, n + LAT});
        has_cap = 1;
        cap_c = n;
      end
      in_meas = 1;
      e = n;
    end else if (in_meas && !bsy && n - e >= T) begin
      sb.push_back('{s ? 100 : 0, 0, 1, n + 1});
      in_meas = 0;
    end
  endtask

  task automatic step(input bit val);
    @(posedge clk);
    #1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1);
    end
    pwm_in = val;
    v[cyc] = val;
    model(cyc);
  endtask

  task automatic hold(input bit val, input int n);
    repeat (n) step(val);
  endtask

  task automatic pulse(input int per, input int hi, input int reps);
    repeat (reps) begin
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pwm_in = 1'b0;
    for (int k = cyc - 2; k <= cyc; k++) if (k >= 0) v[k] = 1'b0;
    sb.delete();
    in_meas = 0;
    has_cap = 0;
    exp_busy = 0;
    #1 chk("reset_outputs", int'(duty_pct) | int'(period_cyc) | int'(meas_valid) | int'(busy) | int'(stuck), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      v[cyc] = 1'b0;
    end
    rst = 1'b1;
    model(cyc);
  endtask

  always @(negedge clk)
    if (rst) begin
      chk("busy", int'(busy), int'(exp_busy));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_report_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (meas_valid) begin
        if (sb.size() == 0) chk("unexpected_meas_valid", int'(meas_valid), 0);
        else begin
          x = sb.pop_front();
          chk("report_cycle", cyc, x.cyc);
          chk("duty_pct", int'(duty_pct), x.duty);
          chk("period_cyc", int'(period_cyc), x.per);
          chk("stuck", int'(stuck), x.stk);
        end
      end
    end

  initial begin
    int per, hi;
    do_reset();
    hold(1'b0, 5);
    pulse(200, 50, 5);
    pulse(200, 199, 4);
    hold(1'b1, T + 40);
    hold(1'b0, 5);
    pulse(100, 40, 3);
    hold(1'b0, T + 40);
    pulse(100, 30, 3);
    pulse(10, 5, 20);
    hold(1'b0, 50);
    pulse(100, 30, 1);
    hold(1'b1, 12);
    do_reset();
    pulse(100, 30, 3);
    do_reset();
    hold(1'b0, 600);
    pulse(150, 60, 3);
    for (int i = 0; i < 25; i++) begin
      per = int'($urandom_range(300, 2));
      hi = int'($urandom_range(per - 1, 1));
      pulse(per, hi, int'($urandom_range(4, 1)));
      if ($urandom_range(9, 0) == 0) hold(bit'($urandom_range(1, 0)), int'($urandom_range(1100, 900)));
      if ($urandom_range(14, 0) == 0) do_reset();
    end
    hold(1'b0, T + LAT + 10);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
